// File: rtl/output_port_bank.sv
// Bank of NPORTS registered CPU output ports with a valid/ack handshake and sticky overrun flags.
// Optional macro OUT_PORT_READBACK_EN adds the combinational rd_status readback of the selected port.
module output_port_bank #(
  parameter int WIDTH  = 8,
  parameter int NPORTS = 4,
  parameter int SELW   = $clog2(NPORTS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [SELW-1:0]          sel_port,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     clr_ovr,
  input  logic [NPORTS-1:0]        ack,
  output logic [NPORTS*WIDTH-1:0]  out_data,
  output logic [NPORTS-1:0]        out_valid,
  output logic [NPORTS-1:0]        overrun
`ifdef OUT_PORT_READBACK_EN
  ,
  output logic [WIDTH+1:0]         rd_status
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } port_state_e;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    port_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovr_q, ovr_d;
    logic             sel_hit, wr_hit, ack_hit, ovr_set;

    // An out-of-range selector matches no port, so writes and clears to it vanish.
    assign sel_hit = (sel_port == SELW'(p));
    assign wr_hit  = we && sel_hit;
    assign ack_hit = ack[p] && (state_q == FULL);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ovr_set = 1'b0;
      case (state_q)
        EMPTY: begin
          if (wr_hit) begin
            state_d = FULL;
            data_d  = in_data;
          end
        end
        FULL: begin
          if (wr_hit && ack_hit) begin
            data_d = in_data;
          end else if (wr_hit) begin
            ovr_set = 1'b1;
          end else if (ack_hit) begin
            state_d = EMPTY;
          end
        end
      endcase
      // A fresh overrun beats a same-cycle clear.
      if (ovr_set) begin
        ovr_d = 1'b1;
      end else if (clr_ovr && sel_hit) begin
        ovr_d = 1'b0;
      end else begin
        ovr_d = ovr_q;
      end
    end

    // NOTE: sequential state uses non-blocking assignments so all ports update from the same pre-edge values.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= EMPTY;
        data_q  <= '0;
        ovr_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        data_q  <= data_d;
        ovr_q   <= ovr_d;
      end
    end

    assign out_data[p*WIDTH +: WIDTH] = data_q;
    assign out_valid[p]               = (state_q == FULL);
    assign overrun[p]                 = ovr_q;
  end

`ifdef OUT_PORT_READBACK_EN
  always_comb begin
    rd_status = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (sel_port == SELW'(p)) begin
        rd_status = {overrun[p], out_valid[p], out_data[p*WIDTH +: WIDTH]};
      end
    end
  end
`endif

endmodule

// File: tb/tb_output_port_bank.sv
// Self-checking bench for output_port_bank: a 4-port and a 3-port instance checked every cycle
// against an array-based model of the port rules, plus literal expectations from the test plan.
module tb_output_port_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [1:0]  sel3 = 2'd3;
  logic [7:0]  in_data = 8'h00;
  logic        clr_ovr = 1'b0;
  logic [3:0]  ack4 = 4'b0;
  logic [2:0]  ack3 = 3'b0;

  logic [31:0] out_data4;
  logic [3:0]  out_valid4, overrun4;
  logic [23:0] out_data3;
  logic [2:0]  out_valid3, overrun3;
`ifdef OUT_PORT_READBACK_EN
  logic [9:0]  rd_status4, rd_status3;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: index 0 is the 4-port bank, index 1 the 3-port bank.
  logic [7:0] m_data [2][4];
  bit         m_val  [2][4];
  bit         m_ovr  [2][4];

  always #5 clk = ~clk;

  output_port_bank #(.WIDTH(8), .NPORTS(4)) dut4 (
    .clk(clk), .reset(reset), .we(we), .sel_port(sel), .in_data(in_data),
    .clr_ovr(clr_ovr), .ack(ack4), .out_data(out_data4), .out_valid(out_valid4),
    .overrun(overrun4)
`ifdef OUT_PORT_READBACK_EN
    , .rd_status(rd_status4)
`endif
  );

  output_port_bank #(.WIDTH(8), .NPORTS(3)) dut3 (
    .clk(clk), .reset(reset), .we(we), .sel_port(sel3), .in_data(in_data),
    .clr_ovr(clr_ovr), .ack(ack3), .out_data(out_data3), .out_valid(out_valid3),
    .overrun(overrun3)
`ifdef OUT_PORT_READBACK_EN
    , .rd_status(rd_status3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one clock edge of the port rules to bank k with n ports.
  task automatic model_step(input int k, input int n, input int s, input logic [3:0] a);
    for (int p = 0; p < n; p++) begin
      bit was_valid, wr, ak;
      was_valid = m_val[k][p];
      wr = we && (s == p);
      ak = a[p] && was_valid;
      if (reset) begin
        m_data[k][p] = 8'h00;
        m_val[k][p]  = 1'b0;
        m_ovr[k][p]  = 1'b0;
      end else begin
        if (wr && (!was_valid || ak)) begin
          m_data[k][p] = in_data;
          m_val[k][p]  = 1'b1;
        end else if (ak) begin
          m_val[k][p] = 1'b0;
        end
        if (wr && was_valid && !ak) m_ovr[k][p] = 1'b1;
        else if (clr_ovr && (s == p)) m_ovr[k][p] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, 4, int'(sel), ack4);
    model_step(1, 3, int'(sel3), {1'b0, ack3});
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; clr_ovr = 1'b0; ack4 = 4'b0; ack3 = 3'b0; reset = 1'b0; sel3 = 2'd3;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] e_d4, e_d3;
      logic [3:0]  e_v4, e_o4;
      logic [2:0]  e_v3, e_o3;
      e_d4 = '0; e_d3 = '0; e_v4 = '0; e_o4 = '0; e_v3 = '0; e_o3 = '0;
      for (int p = 0; p < 4; p++) begin
        e_d4[p*8 +: 8] = m_data[0][p];
        e_v4[p] = m_val[0][p];
        e_o4[p] = m_ovr[0][p];
      end
      for (int p = 0; p < 3; p++) begin
        e_d3[p*8 +: 8] = m_data[1][p];
        e_v3[p] = m_val[1][p];
        e_o3[p] = m_ovr[1][p];
      end
      check("cyc_data4", out_data4, e_d4);
      check("cyc_valid4", {28'b0, out_valid4}, {28'b0, e_v4});
      check("cyc_ovr4", {28'b0, overrun4}, {28'b0, e_o4});
      check("cyc_data3", {8'b0, out_data3}, e_d3);
      check("cyc_valid3", {29'b0, out_valid3}, {29'b0, e_v3});
      check("cyc_ovr3", {29'b0, overrun3}, {29'b0, e_o3});
`ifdef OUT_PORT_READBACK_EN
      check("cyc_rd4", {22'b0, rd_status4},
            {22'b0, m_ovr[0][sel], m_val[0][sel], m_data[0][sel]});
      if (sel3 < 2'd3)
        check("cyc_rd3", {22'b0, rd_status3},
              {22'b0, m_ovr[1][sel3], m_val[1][sel3], m_data[1][sel3]});
      else
        check("cyc_rd3_oor", {22'b0, rd_status3}, 32'h0);
`endif
    end
  end

  initial begin
    // Reset, then idle three cycles.
    idle_inputs();
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    reset = 1'b0;
    repeat (3) step();
    check("rst_data", out_data4, 32'h0);
    check("rst_valid", {28'b0, out_valid4}, 32'h0);
    check("rst_ovr", {28'b0, overrun4}, 32'h0);

    // Single write to port 2.
    we = 1'b1; sel = 2'd2; in_data = 8'hA5;
    step();
    we = 1'b0;
    check("wr_p2_data", {24'b0, out_data4[23:16]}, 32'hA5);
    check("wr_p2_valid", {28'b0, out_valid4}, 32'b0100);
    check("wr_p2_others", {out_data4[31:24], out_data4[15:0]}, 32'h0);
    check("model_p2", {24'b0, m_data[0][2]}, 32'hA5);

    // Overrun on port 1, then clear it.
    we = 1'b1; sel = 2'd1; in_data = 8'h11;
    step();
    in_data = 8'h22;
    step();
    we = 1'b0;
    check("ovr_p1_data", {24'b0, out_data4[15:8]}, 32'h11);
    check("ovr_p1_flag", {28'b0, overrun4}, 32'b0010);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("clr_p1", {28'b0, overrun4}, 32'b0000);

    // New overrun and clear in the same cycle: set wins.
    we = 1'b1; clr_ovr = 1'b1; in_data = 8'h77;
    step();
    we = 1'b0;
    check("set_wins", {28'b0, overrun4}, 32'b0010);
    check("set_wins_data", {24'b0, out_data4[15:8]}, 32'h11);
    step();
    clr_ovr = 1'b0;
    check("clr_again", {28'b0, overrun4}, 32'b0000);

    // Port 0: write with simultaneous ack replaces data, then ack alone empties.
    we = 1'b1; sel = 2'd0; in_data = 8'h33;
    step();
    in_data = 8'h44; ack4 = 4'b0001;
    step();
    we = 1'b0;
    check("wr_ack_data", {24'b0, out_data4[7:0]}, 32'h44);
    check("wr_ack_valid", {28'b0, out_valid4}, 32'b0111);
    check("wr_ack_novr", {31'b0, overrun4[0]}, 32'h0);
    step();
    check("ack_valid", {28'b0, out_valid4}, 32'b0110);
    check("ack_hold", {24'b0, out_data4[7:0]}, 32'h44);
    step();
    check("ack_idle_ign", {28'b0, out_valid4}, 32'b0110);

    // Back-to-back writes with ack held high: one value per cycle, no overrun.
    we = 1'b1; sel = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      in_data = 8'(i);
      step();
      check("b2b_data", {24'b0, out_data4[7:0]}, i);
    end
    we = 1'b0;
    check("b2b_novr", {28'b0, overrun4}, 32'h0);
    step();
    ack4 = 4'b0;
    check("b2b_drain", {31'b0, out_valid4[0]}, 32'h0);

    // Port 1 prepared for readback: data 0x5A, valid, overrun set.
    ack4 = 4'b0010;
    step();
    ack4 = 4'b0;
    we = 1'b1; sel = 2'd1; in_data = 8'h5A;
    step();
    in_data = 8'h99;
    step();
    we = 1'b0;
    check("rb_setup_ovr", {28'b0, overrun4}, 32'b0010);
`ifdef OUT_PORT_READBACK_EN
    check("rd_status_p1", {22'b0, rd_status4}, {22'b0, 10'b11_0101_1010});
`endif

    // Out-of-range selector on the 3-port bank is ignored.
    we = 1'b1; sel = 2'd3; sel3 = 2'd3; in_data = 8'hC3;
    step();
    check("oor_valid3", {29'b0, out_valid3}, 32'h0);
    check("oor_data3", {8'b0, out_data3}, 32'h0);
    check("p3_loaded", {24'b0, out_data4[31:24]}, 32'hC3);
    sel3 = 2'd2; in_data = 8'hD4;
    step();
    check("inr_data3", {8'b0, out_data3}, 32'hD40000);
    check("inr_valid3", {29'b0, out_valid3}, 32'b100);
    in_data = 8'hE1;
    step();
    we = 1'b0; clr_ovr = 1'b1; sel3 = 2'd3;
    step();
    clr_ovr = 1'b0;
    check("oor_clr_ign", {29'b0, overrun3}, 32'b100);

    // Reset mid-handshake with a concurrent write: everything empties.
    reset = 1'b1; we = 1'b1; sel = 2'd3; in_data = 8'hEE;
    step();
    idle_inputs();
    check("mid_rst_data4", out_data4, 32'h0);
    check("mid_rst_valid4", {28'b0, out_valid4}, 32'h0);
    check("mid_rst_ovr4", {28'b0, overrun4}, 32'h0);
    check("mid_rst_3", {out_data3, out_valid3, overrun3}, 32'h0);
    step();
    check("post_rst_idle", {28'b0, out_valid4}, 32'h0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_port_bank.md
# output_port_bank

Parametrised bank of CPU output ports: NPORTS registers of WIDTH bits, loaded by the CPU `out` instruction from the register-file read port. Each port adds a valid/ack handshake toward its external consumer and a sticky overrun flag for writes that arrive before the consumer has taken the previous value. Sits on the CPU datapath beside the register file. Successor of the fixed 4×8-bit output block; it also replaces that block's gated-clock registers with synchronous enables on the single `clk`.

## Interface
Parameters:
- WIDTH, 8, data width of each port
- NPORTS, 4, number of ports (2..16)
- SELW, $clog2(NPORTS), width of the port selector (derived)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- we  input  1  CPU write strobe, sampled each rising edge
- sel_port  input  SELW  target port index for `we` / `clr_ovr`
- in_data  input  WIDTH  write data (register-file RD2)
- clr_ovr  input  1  clear overrun flag of `sel_port`
- ack  input  NPORTS  consumer acknowledge, one bit per port
- out_data  output  NPORTS*WIDTH  port p occupies bits [p*WIDTH +: WIDTH]
- out_valid  output  NPORTS  port p holds data not yet acknowledged
- overrun  output  NPORTS  sticky: a write to port p was dropped
- rd_status  output  WIDTH+2  readback; present only with OUT_PORT_READBACK_EN

## Operation
Per port p, every register updates only on the rising edge of `clk`:
- Reset has priority over everything. `out_data`, `out_valid` and `overrun` all go to 0.
- Write hit: `we=1` and `sel_port==p`.
- Ack hit: `ack[p]=1` and `out_valid[p]=1`. An `ack[p]` while `out_valid[p]=0` is ignored.
- Write hit, `out_valid[p]=0`: load `in_data`, set valid.
- Write hit, `out_valid[p]=1`, ack hit in the same cycle: load `in_data`; valid stays 1, because the old value is consumed and the new one takes its place.
- Write hit, `out_valid[p]=1`, no ack: the write is dropped. Data is unchanged and `overrun[p]` is set.
- Ack hit, no write hit: clear valid; data is held.
- `clr_ovr=1` with `sel_port==p` clears `overrun[p]`. If the same cycle also produces a new overrun on p, the set wins.
- If `sel_port >= NPORTS`, both the write and the clear are ignored, with no side effects.
- Ports are independent. A write to one port never changes another port's state.
- Per-port state machine: EMPTY (valid=0) → FULL on a write. FULL → EMPTY on an ack without a write. FULL → FULL on a write with ack (new data) or a write without ack (overrun).

## Timing
- Write to output: `out_data`/`out_valid` change on the edge that samples `we`, and are visible one cycle later. Latency is 1 cycle.
- Ack to valid low: 1 cycle.
- Back-to-back throughput: one value per cycle per port, provided the consumer holds `ack` high while valid is high.
- Reset is sampled only on the clock edge. Asserting it mid-handshake empties every port on that edge, and any write in the same cycle is lost.
- All outputs are registered. There is no combinational path from inputs to `out_*`, except `rd_status`.

## Configuration
- Macro `OUT_PORT_READBACK_EN`:
  - Defined: `rd_status` exists and is combinational.
  - `rd_status = {overrun[sel_port], out_valid[sel_port], out_data[sel_port]}`.
  - `rd_status` is all zeros when `sel_port >= NPORTS`.
  - Lets the CPU poll a port before writing to it.
- Not defined: the `rd_status` port and its mux are absent, and all other behaviour is identical.

## Test plan
- Reset, then idle 3 cycles → all `out_data`=0, `out_valid`=0, `overrun`=0.
- NPORTS=4, WIDTH=8: write 0xA5 to port 2 → next cycle `out_data[23:16]`=0xA5, `out_valid`=4'b0100; ports 0, 1, 3 remain 0.
- Write 0x11 to port 1, then 0x22 to port 1 with no ack → data stays 0x11, `overrun[1]`=1. Then `clr_ovr` on port 1 → `overrun[1]`=0.
- Port 0 holds 0x33 and is valid. Same cycle: write 0x44 and `ack[0]`=1 → data 0x44, valid stays 1, no overrun. Then `ack[0]` alone → valid 0, data 0x44 held.
- Mid-handshake: port 3 valid, `reset` pulsed for 1 cycle together with `we` to port 3 → all state 0 next cycle. NPORTS=3 with `sel_port`=3: write → no port changes.
- With OUT_PORT_READBACK_EN: port 1 has data 0x5A, valid, overrun set; `sel_port`=1 → `rd_status`=10'b11_0101_1010.
